// File: rtl/rle_stream_scheduler_pkg.sv
// Shared definitions for the row compressor: scheduler FSM encoding, packet header
// layout and channel identifiers.
package compressor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC0 = 3'd1,
        ST_SYNC1 = 3'd2,
        ST_HDR   = 3'd3,
        ST_VAL   = 3'd4,
        ST_CNT   = 3'd5
    } state_e;

    localparam logic [1:0] HDR_PREFIX = 2'b10;

    localparam logic [1:0] CH_Y = 2'd0;
    localparam logic [1:0] CH_U = 2'd1;
    localparam logic [1:0] CH_V = 2'd2;

    // Header byte: prefix, channel id, end-of-row flag, three reserved zero bits.
    function automatic logic [7:0] make_header(input logic [1:0] ch, input logic last);
        return {HDR_PREFIX, ch, last, 3'b000};
    endfunction

endpackage

// File: rtl/rle_stream_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a registered
// pointer, which moves to one past the winner whenever a grant is taken.
module rr_arbiter
    import compressor_pkg::*;
#(
    parameter int NumChannels = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NumChannels-1:0] req_i,
    input  logic                   advance_i,
    output logic [NumChannels-1:0] grant_o,
    output logic [1:0]             grant_idx_o,
    output logic                   grant_valid_o
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;

    // Grant search and pointer update.
    always_comb begin
        int  cand;
        logic hit;
        cand          = 0;
        hit           = 1'b0;
        grant_idx_o   = 2'd0;
        grant_valid_o = 1'b0;
        for (int off = 0; off < NumChannels; off++) begin
            cand = (int'(ptr_q) + off >= NumChannels) ? int'(ptr_q) + off - NumChannels
                                                      : int'(ptr_q) + off;
            hit           = req_i[cand] & ~grant_valid_o;
            grant_idx_o   = hit ? 2'(cand) : grant_idx_o;
            grant_valid_o = grant_valid_o | hit;
        end
        for (int k = 0; k < NumChannels; k++) begin
            grant_o[k] = grant_valid_o & (grant_idx_o == 2'(k));
        end
        if (advance_i && grant_valid_o) begin
            ptr_d = (int'(grant_idx_o) == NumChannels - 1) ? 2'd0 : grant_idx_o + 2'd1;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr_q <= CH_Y;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rle_stream_scheduler.sv
// Serialises (value, count) runs from the Y/U/V RLE channels into 3-byte packets on the
// shared UART TX byte path, inserting a two-byte sync marker at frame boundaries.
module rle_stream_scheduler
    import compressor_pkg::*;
#(
    parameter int         NumChannels = 3,
    parameter logic [7:0] SyncByte0   = 8'hA5,
    parameter logic [7:0] SyncByte1   = 8'h5A
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     i_frame_start,
    input  logic [NumChannels-1:0]   i_run_valid,
    input  logic [8*NumChannels-1:0] i_run_val,
    input  logic [8*NumChannels-1:0] i_run_cnt,
    input  logic [NumChannels-1:0]   i_run_last,
    output logic [NumChannels-1:0]   o_run_ack,
    output logic [7:0]               o_byte,
    output logic                     o_byte_valid,
    input  logic                     i_tx_ready,
    output logic                     o_busy
);

    state_e     state_q, state_d;
    logic       sync_pend_q, sync_pend_d;
    logic       arm_q;
    logic [7:0] val_q, val_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic [1:0] gid_q, gid_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_valid_q, byte_valid_d;
    logic       busy_q, busy_d;

    logic [NumChannels-1:0] req_s;
    logic [NumChannels-1:0] gnt_s;
    logic [1:0]             gnt_idx_s;
    logic                   gnt_valid_s;
    logic                   grant_en_s;
    logic                   xfer_s;
    logic [7:0]             sel_val_s;
    logic [7:0]             sel_cnt_s;
    logic                   sel_last_s;

    // arm_q keeps the ack path quiet while reset is held and for the first cycle after it.
    assign grant_en_s   = arm_q & (state_q == ST_IDLE) & ~sync_pend_q;
    assign req_s        = i_run_valid & {NumChannels{grant_en_s}};
    assign xfer_s       = byte_valid_q & i_tx_ready;
    assign o_run_ack    = gnt_s;
    assign o_byte       = byte_q;
    assign o_byte_valid = byte_valid_q;
    assign o_busy       = busy_q;

    rr_arbiter #(
        .NumChannels(NumChannels)
    ) u_arb (
        .CLK          (CLK),
        .RST          (RST),
        .req_i        (req_s),
        .advance_i    (gnt_valid_s),
        .grant_o      (gnt_s),
        .grant_idx_o  (gnt_idx_s),
        .grant_valid_o(gnt_valid_s)
    );

    // One-hot select of the granted channel's run fields.
    always_comb begin
        sel_val_s  = 8'h00;
        sel_cnt_s  = 8'h00;
        sel_last_s = 1'b0;
        for (int k = 0; k < NumChannels; k++) begin
            sel_val_s  = sel_val_s  | (i_run_val[8*k +: 8] & {8{gnt_s[k]}});
            sel_cnt_s  = sel_cnt_s  | (i_run_cnt[8*k +: 8] & {8{gnt_s[k]}});
            sel_last_s = sel_last_s | (i_run_last[k] & gnt_s[k]);
        end
    end

    // Next state and run capture.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gid_d   = gid_q;
        case (state_q)
            ST_IDLE: begin
                if (sync_pend_q) begin
                    state_d = ST_SYNC0;
                end else if (gnt_valid_s) begin
                    val_d   = sel_val_s;
                    cnt_d   = sel_cnt_s;
                    last_d  = sel_last_s;
                    gid_d   = gnt_idx_s;
                    state_d = (sel_cnt_s == 8'd0) ? ST_IDLE : ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC0: state_d = xfer_s ? ST_SYNC1 : ST_SYNC0;
            ST_SYNC1: state_d = xfer_s ? ST_IDLE  : ST_SYNC1;
            ST_HDR:   state_d = xfer_s ? ST_VAL   : ST_HDR;
            ST_VAL:   state_d = xfer_s ? ST_CNT   : ST_VAL;
            ST_CNT:   state_d = xfer_s ? ST_IDLE  : ST_CNT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Pending sync marker; a pulse while the marker is already going out is absorbed.
    always_comb begin
        if (i_frame_start && (state_q != ST_SYNC0) && (state_q != ST_SYNC1)) begin
            sync_pend_d = 1'b1;
        end else if ((state_q == ST_SYNC1) && xfer_s) begin
            sync_pend_d = 1'b0;
        end else begin
            sync_pend_d = sync_pend_q;
        end
    end

    // Output byte for the state being entered, so the outputs come straight from flops.
    always_comb begin
        byte_d       = 8'h00;
        byte_valid_d = 1'b1;
        case (state_d)
            ST_SYNC0: byte_d = SyncByte0;
            ST_SYNC1: byte_d = SyncByte1;
            ST_HDR:   byte_d = make_header(gid_d, last_d);
            ST_VAL:   byte_d = val_d;
            ST_CNT:   byte_d = cnt_d;
            default: begin
                byte_d       = 8'h00;
                byte_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, capture and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            sync_pend_q  <= 1'b0;
            arm_q        <= 1'b0;
            val_q        <= 8'h00;
            cnt_q        <= 8'h00;
            last_q       <= 1'b0;
            gid_q        <= 2'd0;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_pend_q  <= sync_pend_d;
            arm_q        <= 1'b1;
            val_q        <= val_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            gid_q        <= gid_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
        end
    end

endmodule
